// File: rtl/data_sram_responder.sv
// Data SRAM slave: word RAM plus an MMIO window of LED, timer,
// switch and scratch registers, with one-cycle registered read data.
module data_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  logic [15:0] led;
  logic [31:0] timer;
  logic [31:0] scratch;

  logic              mmio_hit;
  logic [13:0]       mmio_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              wr;
  logic              rd;
  logic              led_we;
  logic              tmr_we;
  logic              scr_we;
  logic              ram_we;
  logic [31:0]       rd_val;
  logic              unused_addr;

  function automatic logic [31:0] merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  assign mmio_hit = sram_addr[31:16] == MMIO_BASE;
  assign mmio_off = sram_addr[15:2];
  assign ram_idx  = sram_addr[ADDR_W+1:2];
  assign unused_addr = ^sram_addr[1:0];

  assign wr = sram_en && (sram_wen != 4'b0000);
  assign rd = sram_en && (sram_wen == 4'b0000);

  assign led_we = wr && mmio_hit && (mmio_off == 14'd0);
  assign tmr_we = wr && mmio_hit && (mmio_off == 14'd1);
  assign scr_we = wr && mmio_hit && (mmio_off == 14'd3);
  assign ram_we = wr && !mmio_hit && !reset;

  assign led_out = led;

  // Read mux: value each target holds at the start of this cycle
  always_comb begin
    rd_val = 32'h0;
    if (mmio_hit) begin
      unique case (mmio_off)
        14'd0:   rd_val = {16'h0, led};
        14'd1:   rd_val = timer;
        14'd2:   rd_val = {16'h0, switch_in};
        14'd3:   rd_val = scratch;
        default: rd_val = 32'h0;
      endcase
    end else begin
      rd_val = mem[ram_idx];
    end
  end

  // Registered read data; holds on idle and write cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rdata <= 32'h0;
    end else if (rd) begin
      sram_rdata <= rd_val;
    end
  end

  // Byte-enabled RAM write; contents are never cleared
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) begin
          mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // LED register: only the low two byte lanes exist
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 16'h0;
    end else if (led_we) begin
      if (sram_wen[0]) led[7:0]  <= sram_wdata[7:0];
      if (sram_wen[1]) led[15:8] <= sram_wdata[15:8];
    end
  end

  // Free-running timer; a write overrides that cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 32'h0;
    end else if (tmr_we) begin
      timer <= merge(timer, sram_wdata, sram_wen);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // Scratch register, byte-enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch <= 32'h0;
    end else if (scr_we) begin
      scratch <= merge(scratch, sram_wdata, sram_wen);
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed test-plan checks plus
// random traffic compared each cycle against a behavioural model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  data_sram_responder #(
    .ADDR_W(12),
    .MMIO_BASE(16'hBFAF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sram_en(sram_en),
    .sram_wen(sram_wen),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .switch_in(switch_in),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int unsigned m_mem   [4096];
  bit          m_known [4096];
  logic [31:0] m_rdata;
  bit          m_rknown = 1'b0;
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [31:0] m_scratch;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o,
      input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    end
    return r;
  endfunction

  // Apply one cycle of inputs, predict, clock, commit prediction
  task automatic do_cycle(input bit rst, input bit en,
      input logic [3:0] wen, input logic [31:0] addr,
      input logic [31:0] wdata);
    logic [31:0] n_rdata, n_timer, n_scr, merged;
    logic [15:0] n_led;
    logic [15:0] off;
    bit          n_rk;
    int          idx;
    reset      = rst;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    n_rdata = m_rdata;
    n_rk    = m_rknown;
    n_led   = m_led;
    n_timer = m_timer + 32'd1;
    n_scr   = m_scratch;
    off     = addr[15:0] & 16'hFFFC;
    idx     = int'((addr >> 2) % 4096);
    if (rst) begin
      n_rdata = 0; n_rk = 1; n_led = 0; n_timer = 0; n_scr = 0;
      if (en && wen != 0 && addr[31:16] != 16'hBFAF) m_known[idx] = 0;
    end else if (en && addr[31:16] == 16'hBFAF) begin
      if (wen == 0) begin
        n_rk = 1;
        case (off)
          16'h0000: n_rdata = {16'h0, m_led};
          16'h0004: n_rdata = m_timer;
          16'h0008: n_rdata = {16'h0, switch_in};
          16'h000C: n_rdata = m_scratch;
          default:  n_rdata = 0;
        endcase
      end else begin
        merged = bmerge({16'h0, m_led}, wdata, {2'b00, wen[1:0]});
        if (off == 16'h0000) n_led = merged[15:0];
        if (off == 16'h0004) n_timer = bmerge(m_timer, wdata, wen);
        if (off == 16'h000C) n_scr = bmerge(m_scratch, wdata, wen);
      end
    end else if (en) begin
      if (wen == 0) begin
        n_rdata = m_mem[idx];
        n_rk    = m_known[idx];
      end else begin
        m_mem[idx] = bmerge(m_mem[idx], wdata, wen);
        if (wen == 4'hF) m_known[idx] = 1;
      end
    end
    @(posedge clk);
    #1;
    m_rdata   = n_rdata;
    m_rknown  = n_rk;
    m_led     = n_led;
    m_timer   = n_timer;
    m_scratch = n_scr;
  endtask

  task automatic rd(input logic [31:0] a);
    do_cycle(0, 1, 4'h0, a, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    do_cycle(0, 1, be, a, d);
  endtask

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rknown) chk("model_rdata", sram_rdata, m_rdata);
      chk("model_led", {16'h0, led_out}, {16'h0, m_led});
    end
  end

  logic [31:0] t0;
  logic [31:0] ra;

  initial begin
    reset = 1; sram_en = 0; sram_wen = 0;
    sram_addr = 0; sram_wdata = 0; switch_in = 16'h0;
    for (int i = 0; i < 4096; i++) m_known[i] = 0;
    @(posedge clk); #1;

    // Reset and timer start
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 4'h0, 32'h0, 32'h0);
    chk_en = 1;
    chk("reset_rdata", sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led_out}, 32'h0);
    rd(32'hBFAF_0004);
    t0 = sram_rdata;
    chk("timer_small", {31'h0, t0 <= 32'd2}, 32'h1);
    rd(32'hBFAF_0004);
    chk("timer_inc", sram_rdata, t0 + 32'd1);

    // RAM byte write
    wr(32'h10, 4'hF, 32'h1122_3344);
    wr(32'h10, 4'b0100, 32'h00AA_0000);
    rd(32'h10);
    chk("ram_byte", sram_rdata, 32'h11AA_3344);

    // Back-to-back reads
    wr(32'h20, 4'hF, 32'd1);
    wr(32'h24, 4'hF, 32'd2);
    wr(32'h28, 4'hF, 32'd3);
    rd(32'h20); chk("b2b_0", sram_rdata, 32'd1);
    rd(32'h24); chk("b2b_1", sram_rdata, 32'd2);
    rd(32'h28); chk("b2b_2", sram_rdata, 32'd3);
    do_cycle(0, 0, 4'h0, 32'h20, 32'h0);
    chk("b2b_hold", sram_rdata, 32'd3);

    // LED and switch
    wr(32'hBFAF_0000, 4'hF, 32'hDEAD_BEEF);
    chk("led_out", {16'h0, led_out}, 32'h0000_BEEF);
    rd(32'hBFAF_0000);
    chk("led_rd", sram_rdata, 32'h0000_BEEF);
    switch_in = 16'h5A5A;
    rd(32'hBFAF_0008);
    chk("switch_rd", sram_rdata, 32'h0000_5A5A);
    wr(32'hBFAF_0008, 4'hF, 32'h1234_5678);
    rd(32'hBFAF_0008);
    chk("switch_ro", sram_rdata, 32'h0000_5A5A);

    // Timer load and wrap
    wr(32'hBFAF_0004, 4'hF, 32'hFFFF_FFFE);
    rd(32'hBFAF_0004); chk("tmr_ld", sram_rdata, 32'hFFFF_FFFE);
    rd(32'hBFAF_0004); chk("tmr_ff", sram_rdata, 32'hFFFF_FFFF);
    rd(32'hBFAF_0004); chk("tmr_wrap", sram_rdata, 32'h0);

    // Scratch, unmapped, aliasing
    wr(32'hBFAF_000C, 4'b1001, 32'hA1B2_C3D4);
    rd(32'hBFAF_000C); chk("scratch", sram_rdata, 32'hA100_00D4);
    rd(32'hBFAF_0100); chk("unmapped", sram_rdata, 32'h0);
    wr(32'h4010, 4'hF, 32'hCAFE_F00D);
    rd(32'h10); chk("alias", sram_rdata, 32'hCAFE_F00D);

    // Reset wins over a concurrent MMIO write
    do_cycle(1, 1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFF);
    chk("rst_win_led", {16'h0, led_out}, 32'h0);
    chk("rst_win_rd", sram_rdata, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] be;
      bit         en_r, rst_r;
      switch_in = 16'($urandom);
      rst_r = ($urandom_range(0, 199) == 0);
      en_r  = ($urandom_range(0, 9) < 8);
      be    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 2) == 0)
        ra = {16'hBFAF, 16'($urandom_range(0, 20))};
      else if ($urandom_range(0, 9) == 0)
        ra = 32'hBFAF_0100;
      else
        ra = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0,
              4'($urandom), 6'h0, 4'($urandom), 2'($urandom)};
      if (ra[31:16] == 16'hBFAF && ra[15:0] > 16'h0100)
        ra = 32'hBFAF_0100;
      do_cycle(rst_r, en_r, be, ra, $urandom);
    end

    do_cycle(0, 0, 4'h0, 32'h0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave-side responder for the CPU core's data SRAM interface (en / wen / addr / wdata / rdata).
- Serves loads and stores from a local word-addressed RAM.
- Also decodes a small MMIO window holding LED, free-running timer, switch and scratch registers.
- Sits in the SoC wrapper directly below the CPU top and returns read data with the fixed one-cycle latency the pipeline's MEM stage expects.

Parameters:
- ADDR_W, 12: RAM index width; RAM depth = 2^ADDR_W 32-bit words.
- MMIO_BASE, 16'hBFAF: value of sram_addr[31:16] that selects the MMIO window.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- sram_en  input  1  access request this cycle.
- sram_wen  input  4  byte write enables; bit i writes wdata[8i+7:8i]; 4'b0000 = read.
- sram_addr  input  32  byte address; [1:0] ignored (word access).
- sram_wdata  input  32  store data.
- sram_rdata  output  32  read data, valid the cycle after a read request.
- switch_in  input  16  external switch levels.
- led_out  output  16  LED register contents.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Reset values:
  - sram_rdata = 0, led_out = 0, timer = 0, scratch = 0.
  - RAM contents are not reset.
- Decode, evaluated when sram_en = 1:
  - MMIO hit when sram_addr[31:16] == MMIO_BASE. Offset = sram_addr[15:0] with bits [1:0] masked.
  - Otherwise RAM. Index = sram_addr[ADDR_W+1:2]; upper address bits are ignored, so addresses alias modulo the RAM size.
- MMIO map:
  - 0x0000 LED: RW. Bits [15:0] hold state. wen[0] and wen[1] write the two bytes; wen[3:2] are ignored. Reads return {16'b0, led}.
  - 0x0004 TIMER: RW, 32 bits, increments by 1 every cycle and wraps from FFFF_FFFF to 0.
  - 0x0008 SWITCH: RO. Reads return {16'b0, switch_in} sampled in the request cycle. Writes are ignored.
  - 0x000C SCRATCH: RW, 32 bits, byte-enabled.
  - Any other offset: reads return 0, writes are ignored.
- Read timing:
  - A request in cycle N with sram_en = 1 and wen = 0 drives sram_rdata in cycle N+1 with the value the target held at the start of cycle N.
  - sram_rdata is registered; it holds its last value when sram_en = 0 or when the request is a write.
- Write timing:
  - sram_en = 1 with wen != 0 updates only the enabled bytes at the clock edge ending cycle N.
  - wen != 0 with sram_en = 0 is ignored.
- Timer write: the written bytes merge over the pre-increment value and take priority over the increment in that cycle. The timer reads the written value the next cycle, then resumes incrementing.
- Read-after-write to the same word in consecutive cycles returns the new data.
- Reset asserted in the same cycle as a request: reset wins, and the access has no effect on MMIO registers or sram_rdata. A RAM write in that cycle may or may not land (don't-care).
- No back-pressure: every request is accepted, and a new request may be issued every cycle.

Test Plan:
- Reset check: hold reset 3 cycles, then release -> sram_rdata = 0, led_out = 0; reading TIMER immediately returns a small value (≤ 2) that then increments by 1 per cycle.
- RAM byte write: write addr 0x0000_0010, wen 4'b1111, data 0x1122_3344; next cycle write wen 4'b0100, data 0x00AA_0000; read addr 0x0000_0010 -> sram_rdata = 0x11AA_3344 one cycle after the read request.
- Back-to-back RAM reads: read addresses 0x20, 0x24, 0x28 on consecutive cycles after preloading 1, 2, 3 -> sram_rdata shows 1, 2, 3 on consecutive cycles starting one cycle after the first request; with sram_en = 0 afterwards, rdata holds 3.
- LED and switch: write 0xBFAF_0000, wen 4'b1111, data 0xDEAD_BEEF -> led_out = 0xBEEF and a read returns 0x0000_BEEF. With switch_in = 0x5A5A, read 0xBFAF_0008 -> 0x0000_5A5A. Write 0xBFAF_0008 -> no change.
- Timer load and wrap: write TIMER = 0xFFFF_FFFE -> reads in the next two cycles return 0xFFFF_FFFE and 0xFFFF_FFFF, the following read returns 0x0000_0000.
- Unmapped and aliasing: read 0xBFAF_0100 -> 0. Write 0x0000_4010 (ADDR_W = 12) with 0xCAFE_F00D -> reading 0x0000_0010 returns 0xCAFE_F00D.
